// File: rtl/mem_port_arbiter_if.sv
// Bundle of request/response handshakes and the memory-side bus around the shared port.
// slave = arbiter side, master = core + memory side.
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        ls_req_valid;
  logic        ls_req_we;
  logic [3:0]  ls_req_be;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    input  ls_req_valid, ls_req_we, ls_req_be, ls_req_addr, ls_req_wdata,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    output ls_req_valid, ls_req_we, ls_req_be, ls_req_addr, ls_req_wdata,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store: one transaction
// in flight, fixed read latency, LS priority with a starvation bound for fetch.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave io_bus
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] C_WAIT_INIT  = CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [CW-1:0] r_wait_cnt;
  logic [SW-1:0] r_starve_cnt;
  logic        r_is_ls;
  logic        r_kill;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_if_rsp_valid;
  logic        r_ls_rsp_valid;
  logic [31:0] r_if_rsp_data;
  logic [31:0] r_ls_rsp_data;

  logic        w_if_win;
  logic        w_ls_win;
  logic        w_accept;
  logic        w_done;
  logic        w_mem_en;
  logic        w_busy;
  logic        w_if_deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_if_win     = 1'b0;
    w_ls_win     = 1'b0;
    w_mem_en     = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy   = 1'b0;
        w_if_win = io_bus.if_req_valid &&
                   (!io_bus.ls_req_valid || (r_starve_cnt == C_STARVE_MAX));
        w_ls_win = io_bus.ls_req_valid && !w_if_win;
        if (w_if_win || w_ls_win) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_mem_en     = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = w_if_win || w_ls_win;
  // The completion cycle is still inside the flush window of a fetch.
  assign w_if_deliver = w_done && !r_is_ls && !r_kill && !io_bus.if_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt     <= '0;
      r_starve_cnt   <= '0;
      r_is_ls        <= 1'b0;
      r_kill         <= 1'b0;
      r_we           <= 1'b0;
      r_be           <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_if_rsp_valid <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_ls_rsp_data  <= '0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= C_WAIT_INIT;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end

      if (w_accept) begin
        r_is_ls <= w_ls_win;
        r_kill  <= w_if_win && io_bus.if_flush;
        r_we    <= w_ls_win && io_bus.ls_req_we;
        r_be    <= w_ls_win ? io_bus.ls_req_be : 4'b1111;
        r_addr  <= w_ls_win ? io_bus.ls_req_addr : io_bus.if_req_addr;
        r_wdata <= w_ls_win ? io_bus.ls_req_wdata : 32'd0;
      end else if (w_busy && !r_is_ls && io_bus.if_flush) begin
        r_kill <= 1'b1;
      end

      if (w_if_win) begin
        r_starve_cnt <= '0;
      end else if (w_ls_win && io_bus.if_req_valid && (r_starve_cnt != C_STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      r_if_rsp_valid <= w_if_deliver;
      r_ls_rsp_valid <= w_done && r_is_ls;
      if (w_if_deliver) begin
        r_if_rsp_data <= io_bus.mem_rdata;
      end
      if (w_done && r_is_ls) begin
        r_ls_rsp_data <= r_we ? 32'd0 : io_bus.mem_rdata;
      end
    end
  end

  // Readies are forced low while reset is held even though the FSM already sits in IDLE.
  assign io_bus.if_req_ready = w_if_win && rst_n;
  assign io_bus.ls_req_ready = w_ls_win && rst_n;
  assign io_bus.if_rsp_valid = r_if_rsp_valid;
  assign io_bus.if_rsp_data  = r_if_rsp_data;
  assign io_bus.ls_rsp_valid = r_ls_rsp_valid;
  assign io_bus.ls_rsp_data  = r_ls_rsp_data;
  assign io_bus.mem_en       = w_mem_en;
  assign io_bus.mem_we       = r_we;
  assign io_bus.mem_be       = r_be;
  assign io_bus.mem_addr     = r_addr;
  assign io_bus.mem_wdata    = r_wdata;
  assign io_bus.busy         = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed tables and sequences plus random traffic, all
// cross-checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int L   = 2;
  localparam int LIM = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if u_if ();
  mem_port_arbiter_if u_if0 ();

  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(u_if.slave));

  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .io_bus(u_if0.slave));

  always_comb begin
    u_if0.if_req_valid = u_if.if_req_valid;
    u_if0.if_req_addr  = u_if.if_req_addr;
    u_if0.if_flush     = u_if.if_flush;
    u_if0.ls_req_valid = u_if.ls_req_valid;
    u_if0.ls_req_we    = u_if.ls_req_we;
    u_if0.ls_req_be    = u_if.ls_req_be;
    u_if0.ls_req_addr  = u_if.ls_req_addr;
    u_if0.ls_req_wdata = u_if.ls_req_wdata;
    u_if0.mem_rdata    = 32'd0;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory: data for an access is presented only around the end of cycle mem_en+L.
  logic        pipe_v [0:L];
  logic [31:0] pipe_a [0:L];
  initial begin
    for (int i = 0; i <= L; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = 32'd0;
    end
    u_if.mem_rdata = 32'd0;
  end
  always @(negedge clk) begin
    for (int i = L; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = u_if.mem_en;
    pipe_a[0] = u_if.mem_addr;
    u_if.mem_rdata = pipe_v[L] ? mem_f(pipe_a[L]) : $urandom();
  end

  // Transaction-level reference model, evaluated once per cycle at the falling edge.
  int          cyc = 0;
  int          idle_at = 0;
  int          starve = 0;
  bit          have_txn = 0;
  int          t_acc = 0;
  bit          t_ls, t_we, t_kill;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;
  logic [31:0] last_if = 0, last_ls = 0;
  byte         q_grant[$];
  int          q_acc[$];
  int          d0_if_acc = 0, d0_ls_acc = 0;

  always @(negedge clk) begin : monitor
    bit idle, e_ifr, e_lsr, e_men, e_ifv, e_lsv;
    if (!rst_n) begin
      chk("rst_if_ready", u_if.if_req_ready, 0);
      chk("rst_ls_ready", u_if.ls_req_ready, 0);
      chk("rst_busy", u_if.busy, 0);
      chk("rst_mem_en", u_if.mem_en, 0);
      chk("rst_mem_addr", u_if.mem_addr, 0);
      chk("rst_if_rsp_valid", u_if.if_rsp_valid, 0);
      chk("rst_ls_rsp_valid", u_if.ls_rsp_valid, 0);
      chk("rst_ls_rsp_data", u_if.ls_rsp_data, 0);
      have_txn = 0;
      idle_at  = cyc;
      starve   = 0;
      last_if  = 0;
      last_ls  = 0;
    end else begin
      idle  = (cyc >= idle_at);
      e_ifr = idle && u_if.if_req_valid && (!u_if.ls_req_valid || starve == LIM);
      e_lsr = idle && u_if.ls_req_valid && !e_ifr;
      chk("if_ready", u_if.if_req_ready, e_ifr);
      chk("ls_ready", u_if.ls_req_ready, e_lsr);
      chk("busy", u_if.busy, !idle);

      e_men = have_txn && (cyc == t_acc + 1);
      chk("mem_en", u_if.mem_en, e_men);
      if (e_men) begin
        chk("mem_addr", u_if.mem_addr, t_addr);
        chk("mem_we", u_if.mem_we, t_we);
        if (t_ls) begin
          chk("mem_be", u_if.mem_be, t_be);
          chk("mem_wdata", u_if.mem_wdata, t_wdata);
        end
      end

      e_ifv = 0;
      e_lsv = 0;
      if (have_txn && cyc == t_acc + L + 2) begin
        if (t_ls) begin
          e_lsv   = 1;
          last_ls = t_we ? 32'd0 : mem_f(t_addr);
        end else if (!t_kill) begin
          e_ifv   = 1;
          last_if = mem_f(t_addr);
        end
        have_txn = 0;
      end
      chk("if_rsp_valid", u_if.if_rsp_valid, e_ifv);
      chk("ls_rsp_valid", u_if.ls_rsp_valid, e_lsv);
      chk("if_rsp_data", u_if.if_rsp_data, last_if);
      chk("ls_rsp_data", u_if.ls_rsp_data, last_ls);

      if (have_txn && !t_ls && u_if.if_flush && cyc <= t_acc + 1 + L) t_kill = 1;

      if (e_ifr || e_lsr) begin
        have_txn = 1;
        t_acc    = cyc;
        t_ls     = e_lsr;
        t_we     = e_lsr && u_if.ls_req_we;
        t_be     = u_if.ls_req_be;
        t_addr   = e_lsr ? u_if.ls_req_addr : u_if.if_req_addr;
        t_wdata  = u_if.ls_req_wdata;
        t_kill   = e_ifr && u_if.if_flush;
        if (e_ifr) starve = 0;
        else if (u_if.if_req_valid && starve < LIM) starve++;
        idle_at = cyc + L + 2;
        q_grant.push_back(e_lsr ? "L" : "I");
        q_acc.push_back(cyc);
      end

      if (u_if0.if_req_ready && u_if0.if_req_valid) d0_if_acc++;
      if (u_if0.ls_req_ready && u_if0.ls_req_valid) d0_ls_acc++;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    u_if.if_req_valid = 0;
    u_if.ls_req_valid = 0;
    u_if.if_flush     = 0;
  endtask

  task automatic wait_ready(input bit ls);
    int k = 0;
    #1;
    while (k < 20 && !(ls ? u_if.ls_req_ready : u_if.if_req_ready)) begin
      @(posedge clk);
      #3;
      k++;
    end
    if (k >= 20) chk(ls ? "ls_ready_timeout" : "if_ready_timeout", 0, 1);
  endtask

  typedef struct {
    logic        ifv, lsv, e_ifr, e_lsr;
  } rdy_vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, e_data;
  } ls_vec_t;

  initial begin : timeout
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rdy_vec_t rv[4];
    ls_vec_t  lv[5];
    string    order;
    int       npulse;

    rv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    rv[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    rv[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    rv[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    lv[0] = '{1'b0, 4'b1111, 32'h0000_0100, 32'h0,         32'hDEADBEEF};
    lv[1] = '{1'b1, 4'b0011, 32'h0000_0200, 32'h0000_1234, 32'h0};
    lv[2] = '{1'b0, 4'b1111, 32'h0000_2000, 32'h0,         mem_f(32'h2000)};
    lv[3] = '{1'b1, 4'b1111, 32'h0000_0400, 32'hCAFEF00D,  32'h0};
    lv[4] = '{1'b0, 4'b0100, 32'hFFFF_FFFC, 32'h0,         mem_f(32'hFFFF_FFFC)};

    drive_idle();
    u_if.if_req_addr  = 0;
    u_if.ls_req_we    = 0;
    u_if.ls_req_be    = 0;
    u_if.ls_req_addr  = 0;
    u_if.ls_req_wdata = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Combinational arbitration with a fresh starvation count; inputs dropped before the edge.
    foreach (rv[i]) begin
      u_if.if_req_valid = rv[i].ifv;
      u_if.ls_req_valid = rv[i].lsv;
      #1;
      chk($sformatf("rdy_tab%0d_if", i), u_if.if_req_ready, rv[i].e_ifr);
      chk($sformatf("rdy_tab%0d_ls", i), u_if.ls_req_ready, rv[i].e_lsr);
      drive_idle();
      tick();
    end

    // Load/store transactions with exact cycle positions.
    foreach (lv[i]) begin
      u_if.ls_req_valid = 1;
      u_if.ls_req_we    = lv[i].we;
      u_if.ls_req_be    = lv[i].be;
      u_if.ls_req_addr  = lv[i].addr;
      u_if.ls_req_wdata = lv[i].wdata;
      wait_ready(1);
      tick();
      u_if.ls_req_valid = 0;
      #1;
      chk($sformatf("ls_tab%0d_mem_en", i), u_if.mem_en, 1);
      chk($sformatf("ls_tab%0d_addr", i), u_if.mem_addr, lv[i].addr);
      chk($sformatf("ls_tab%0d_we", i), u_if.mem_we, lv[i].we);
      chk($sformatf("ls_tab%0d_be", i), u_if.mem_be, lv[i].be);
      if (lv[i].we) chk($sformatf("ls_tab%0d_wdata", i), u_if.mem_wdata, lv[i].wdata);
      tick();
      chk($sformatf("ls_tab%0d_early2", i), u_if.ls_rsp_valid, 0);
      tick();
      chk($sformatf("ls_tab%0d_early3", i), u_if.ls_rsp_valid, 0);
      tick();
      chk($sformatf("ls_tab%0d_rsp_valid", i), u_if.ls_rsp_valid, 1);
      chk($sformatf("ls_tab%0d_rsp_data", i), u_if.ls_rsp_data, lv[i].e_data);
      tick();
      chk($sformatf("ls_tab%0d_pulse_end", i), u_if.ls_rsp_valid, 0);
    end

    // Both ports continuously valid, starting from a cleared starvation count.
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    q_grant.delete();
    q_acc.delete();
    d0_if_acc = 0;
    d0_ls_acc = 0;
    u_if.ls_req_we    = 0;
    u_if.ls_req_addr  = 32'h300;
    u_if.if_req_addr  = 32'h340;
    u_if.ls_req_valid = 1;
    u_if.if_req_valid = 1;
    repeat (24) tick();
    drive_idle();
    repeat (6) tick();
    order = "LLILLI";
    chk("grant_count", q_grant.size(), 6);
    for (int k = 0; k < 6 && k < q_grant.size(); k++)
      chk($sformatf("grant_order%0d", k), q_grant[k], order[k]);
    for (int k = 1; k < q_acc.size(); k++)
      chk($sformatf("accept_interval%0d", k), q_acc[k] - q_acc[k-1], L + 2);
    chk("limit0_if_accepts", d0_if_acc, 6);
    chk("limit0_ls_accepts", d0_ls_acc, 0);

    // Fetch flushed at T+2, then a fetch accepted at T+4 completes normally.
    u_if.if_req_addr  = 32'h800;
    u_if.if_req_valid = 1;
    wait_ready(0);
    tick();
    u_if.if_req_valid = 0;
    #1;
    chk("flush_mem_en", u_if.mem_en, 1);
    chk("flush_mem_we", u_if.mem_we, 0);
    chk("flush_mem_addr", u_if.mem_addr, 32'h800);
    tick();
    u_if.if_flush = 1;
    tick();
    u_if.if_flush = 0;
    tick();
    chk("flush_suppressed", u_if.if_rsp_valid, 0);
    u_if.if_req_addr  = 32'h900;
    u_if.if_req_valid = 1;
    #1;
    chk("flush_next_ready", u_if.if_req_ready, 1);
    tick();
    u_if.if_req_valid = 0;
    repeat (3) tick();
    chk("flush_next_rsp_valid", u_if.if_rsp_valid, 1);
    chk("flush_next_rsp_data", u_if.if_rsp_data, mem_f(32'h900));
    tick();

    // Reset asserted while a load waits for memory.
    u_if.ls_req_we    = 0;
    u_if.ls_req_addr  = 32'h500;
    u_if.ls_req_valid = 1;
    wait_ready(1);
    tick();
    u_if.ls_req_valid = 0;
    tick();
    u_if.if_req_valid = 1;
    rst_n = 0;
    #1;
    chk("rstwait_busy", u_if.busy, 0);
    chk("rstwait_mem_en", u_if.mem_en, 0);
    chk("rstwait_if_ready", u_if.if_req_ready, 0);
    tick();
    tick();
    u_if.if_req_valid = 0;
    u_if.ls_req_addr  = 32'h600;
    u_if.ls_req_valid = 1;
    rst_n = 1;
    #1;
    chk("release_ls_ready", u_if.ls_req_ready, 1);
    npulse = 0;
    tick();
    u_if.ls_req_valid = 0;
    for (int k = 0; k < 6; k++) begin
      if (u_if.ls_rsp_valid) begin
        npulse++;
        chk("release_rsp_data", u_if.ls_rsp_data, mem_f(32'h600));
      end
      tick();
    end
    chk("release_rsp_pulses", npulse, 1);

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      u_if.if_req_valid = ($urandom_range(0, 9) < 7);
      u_if.if_req_addr  = {$urandom(), 2'b00} & 32'h0000_FFFC;
      u_if.ls_req_valid = ($urandom_range(0, 1) == 1);
      u_if.ls_req_we    = $urandom_range(0, 1);
      u_if.ls_req_be    = 4'($urandom());
      u_if.ls_req_addr  = $urandom();
      u_if.ls_req_wdata = $urandom();
      u_if.if_flush     = ($urandom_range(0, 9) == 0);
      tick();
    end
    drive_idle();
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
